// File: rtl/alu_secuencial.sv
// Sequential ALU: single-cycle logic/arith/shift ops plus an optional shift-add multiplier.
// Define ALU_MUL_EN to build the multi-cycle MUL state, datapath and iteration counter.
module alu_secuencial #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] datoA,
    input  logic [WIDTH-1:0] datoB,
    input  logic [3:0]       opCode,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] salida,
    output logic             cout,
    output logic             zero,
    output logic             neg,
    output logic             ovf
);

    localparam int unsigned SHW = $clog2(WIDTH);

    localparam logic [3:0] OpAnd = 4'b0000;
    localparam logic [3:0] OpEor = 4'b0001;
    localparam logic [3:0] OpSub = 4'b0010;
    localparam logic [3:0] OpAdd = 4'b0100;
    localparam logic [3:0] OpOrr = 4'b1100;
    localparam logic [3:0] OpLsl = 4'b1010;
    localparam logic [3:0] OpLsr = 4'b1011;

    logic [WIDTH:0]   w_add;
    logic [WIDTH:0]   w_sub;
    logic [SHW-1:0]   w_shamt;
    logic [WIDTH:0]   w_shl;
    logic [WIDTH:0]   w_shr;
    logic [WIDTH-1:0] w_res;
    logic             w_cout;
    logic             w_ovf;
    logic             w_single;
    logic             w_fin;
    logic [WIDTH-1:0] w_fin_res;

    logic [WIDTH-1:0] r_salida;
    logic             r_cout;
    logic             r_zero;
    logic             r_neg;
    logic             r_ovf;
    logic             r_done;

    assign w_add   = {1'b0, datoA} + {1'b0, datoB} + {{WIDTH{1'b0}}, cin};
    assign w_sub   = {1'b0, datoA} + {1'b0, ~datoB} + {{WIDTH{1'b0}}, 1'b1};
    assign w_shamt = datoB[SHW-1:0];
    // One guard bit on each side catches the last bit shifted out (0 when shamt is 0).
    assign w_shl   = {1'b0, datoA} << w_shamt;
    assign w_shr   = {datoA, 1'b0} >> w_shamt;

    always_comb begin
        w_res  = '0;
        w_cout = 1'b0;
        w_ovf  = 1'b0;
        case (opCode)
            OpAnd: w_res = datoA & datoB;
            OpEor: w_res = datoA ^ datoB;
            OpOrr: w_res = datoA | datoB;
            OpAdd: begin
                w_res  = w_add[WIDTH-1:0];
                w_cout = w_add[WIDTH];
                w_ovf  = (datoA[WIDTH-1] == datoB[WIDTH-1]) &&
                         (w_add[WIDTH-1] != datoA[WIDTH-1]);
            end
            OpSub: begin
                w_res  = w_sub[WIDTH-1:0];
                w_cout = w_sub[WIDTH];
                w_ovf  = (datoA[WIDTH-1] != datoB[WIDTH-1]) &&
                         (w_sub[WIDTH-1] != datoA[WIDTH-1]);
            end
            OpLsl: begin
                w_res  = w_shl[WIDTH-1:0];
                w_cout = w_shl[WIDTH];
            end
            OpLsr: begin
                w_res  = w_shr[WIDTH:1];
                w_cout = w_shr[0];
            end
            default: ;
        endcase
    end

`ifdef ALU_MUL_EN
    localparam logic [3:0] OpMul = 4'b1001;

    typedef enum logic {StIdle, StMul} state_e;

    state_e           r_state;
    state_e           w_state_next;
    logic [WIDTH-1:0] r_mcand;
    logic [WIDTH-1:0] r_mplier;
    logic [WIDTH-1:0] r_acc;
    logic [SHW-1:0]   r_cnt;
    logic             w_mul_go;
    logic             w_mul_last;
    logic [WIDTH-1:0] w_acc_sum;

    assign w_mul_go   = start && (opCode == OpMul);
    assign w_mul_last = (r_cnt == SHW'(WIDTH - 1));
    assign w_acc_sum  = r_acc + (r_mplier[0] ? r_mcand : '0);
    assign w_fin_res  = w_acc_sum;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            StIdle:  if (w_mul_go) w_state_next = StMul;
            StMul:   if (w_mul_last) w_state_next = StIdle;
            default: w_state_next = StIdle;
        endcase
    end

    always_comb begin
        busy     = 1'b0;
        w_single = 1'b0;
        w_fin    = 1'b0;
        case (r_state)
            StIdle:  w_single = start && !w_mul_go;
            StMul: begin
                busy  = 1'b1;
                w_fin = w_mul_last;
            end
            default: ;
        endcase
    end

    // Operands are captured on acceptance so later input changes cannot disturb the product.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mcand  <= '0;
            r_mplier <= '0;
            r_acc    <= '0;
            r_cnt    <= '0;
        end else if ((r_state == StIdle) && w_mul_go) begin
            r_mcand  <= datoA;
            r_mplier <= datoB;
            r_acc    <= '0;
            r_cnt    <= '0;
        end else if (r_state == StMul) begin
            r_acc    <= w_acc_sum;
            r_mcand  <= r_mcand << 1;
            r_mplier <= r_mplier >> 1;
            r_cnt    <= r_cnt + SHW'(1);
        end
    end
`else
    assign busy      = 1'b0;
    assign w_single  = start;
    assign w_fin     = 1'b0;
    assign w_fin_res = '0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_salida <= '0;
            r_cout   <= 1'b0;
            r_zero   <= 1'b1;
            r_neg    <= 1'b0;
            r_ovf    <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_done <= w_single || w_fin;
            if (w_single) begin
                r_salida <= w_res;
                r_cout   <= w_cout;
                r_ovf    <= w_ovf;
                r_zero   <= (w_res == '0);
                r_neg    <= w_res[WIDTH-1];
            end else if (w_fin) begin
                r_salida <= w_fin_res;
                r_cout   <= 1'b0;
                r_ovf    <= 1'b0;
                r_zero   <= (w_fin_res == '0);
                r_neg    <= w_fin_res[WIDTH-1];
            end
        end
    end

    assign salida = r_salida;
    assign cout   = r_cout;
    assign zero   = r_zero;
    assign neg    = r_neg;
    assign ovf    = r_ovf;
    assign done   = r_done;

endmodule

// File: tb/tb_alu_secuencial.sv
// Self-checking bench for alu_secuencial (WIDTH=32); follows ALU_MUL_EN to pick MUL expectations.
module tb_alu_secuencial;

    localparam int W = 32;
`ifdef ALU_MUL_EN
    localparam bit MulEn = 1'b1;
`else
    localparam bit MulEn = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [W-1:0] datoA = '0;
    logic [W-1:0] datoB = '0;
    logic [3:0]   opCode = '0;
    logic         cin = 1'b0;
    logic         busy;
    logic         done;
    logic [W-1:0] salida;
    logic         cout;
    logic         zero;
    logic         neg;
    logic         ovf;

    int n_tests = 0;
    int n_fail  = 0;

    alu_secuencial #(.WIDTH(W)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .datoA  (datoA),
        .datoB  (datoB),
        .opCode (opCode),
        .cin    (cin),
        .busy   (busy),
        .done   (done),
        .salida (salida),
        .cout   (cout),
        .zero   (zero),
        .neg    (neg),
        .ovf    (ovf)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] res;
        logic        c;
        logic        z;
        logic        n;
        logic        v;
        int          lat;
    } exp_t;

    // Reference model: plain 64-bit arithmetic on the architectural definition of each op.
    function automatic exp_t model(input logic [3:0] op, input logic [31:0] a,
                                   input logic [31:0] b, input logic ci);
        exp_t e;
        longint unsigned wide;
        longint sa;
        longint sb;
        longint sr;
        int s;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        s = int'(b[4:0]);
        e.res = '0; e.c = 1'b0; e.v = 1'b0; e.lat = 1;
        case (op)
            4'd0:  e.res = a & b;
            4'd1:  e.res = a ^ b;
            4'd12: e.res = a | b;
            4'd4: begin
                wide = longint'(a) + longint'(b) + longint'(ci);
                e.res = wide[31:0];
                e.c = wide[32];
                sr = sa + sb + longint'(ci);
                e.v = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
            end
            4'd2: begin
                e.res = a - b;
                e.c = (a >= b);
                sr = sa - sb;
                e.v = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
            end
            4'd10: begin
                e.res = a << s;
                e.c = (s != 0) ? a[32 - s] : 1'b0;
            end
            4'd11: begin
                e.res = a >> s;
                e.c = (s != 0) ? a[s - 1] : 1'b0;
            end
            4'd9: begin
                if (MulEn) begin
                    wide = longint'(a) * longint'(b);
                    e.res = wide[31:0];
                    e.lat = W + 1;
                end
            end
            default: ;
        endcase
        e.z = (e.res == 32'd0);
        e.n = e.res[31];
        return e;
    endfunction

    // Drives one start pulse and waits (bounded) for done; the caller does the checking.
    task automatic do_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic ci, output logic [31:0] r, output logic [3:0] flg,
                         output int lat, output int busy_cyc);
        @(negedge clk);
        opCode = op; datoA = a; datoB = b; cin = ci; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        lat = 1;
        busy_cyc = 0;
        while (done !== 1'b1 && lat < 200) begin
            if (busy === 1'b1) busy_cyc++;
            @(negedge clk);
            lat++;
        end
        r = salida;
        flg = {cout, zero, neg, ovf};
    endtask

    task automatic test_reset();
        #12;
        n_tests++;
        if ({salida, cout, zero, neg, ovf, busy, done} !== {32'd0, 6'b010000}) begin
            n_fail++;
            $display("FAIL reset_state: got salida=%h c/z/n/v/busy/done=%b%b%b%b%b%b want 0 010000",
                     salida, cout, zero, neg, ovf, busy, done);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_directed();
        logic [31:0] r;
        logic [3:0]  f;
        int lat, bc;
        do_op(4'b0100, 32'hFFFF_FFFF, 32'h1, 1'b0, r, f, lat, bc);
        n_tests++;
        if ({r, f, lat} !== {32'h0, 4'b1100, 32'd1}) begin
            n_fail++;
            $display("FAIL add_wrap: got %h cznv=%b lat=%0d want 0 1100 lat=1", r, f, lat);
        end
        @(negedge clk);
        n_tests++;
        if (done !== 1'b0) begin
            n_fail++;
            $display("FAIL add_done_single: got done=%b want 0", done);
        end
        do_op(4'b0010, 32'h8000_0000, 32'h1, 1'b0, r, f, lat, bc);
        n_tests++;
        if ({r, f} !== {32'h7FFF_FFFF, 4'b1001}) begin
            n_fail++;
            $display("FAIL sub_ovf: got %h cznv=%b want 7fffffff 1001", r, f);
        end
        datoA = 32'h1234_5678; datoB = 32'h9; opCode = 4'b0000;
        repeat (3) @(negedge clk);
        n_tests++;
        if ({salida, cout, zero, neg, ovf} !== {32'h7FFF_FFFF, 4'b1001}) begin
            n_fail++;
            $display("FAIL hold: got %h cznv=%b%b%b%b want 7fffffff 1001", salida, cout, zero,
                     neg, ovf);
        end
        do_op(4'b1010, 32'h8000_0001, 32'h1, 1'b0, r, f, lat, bc);
        n_tests++;
        if ({r, f} !== {32'h2, 4'b1000}) begin
            n_fail++;
            $display("FAIL lsl_one: got %h cznv=%b want 00000002 1000", r, f);
        end
        do_op(4'b1111, 32'hDEAD_BEEF, 32'h5, 1'b1, r, f, lat, bc);
        n_tests++;
        if ({r, f, lat} !== {32'h0, 4'b0100, 32'd1}) begin
            n_fail++;
            $display("FAIL illegal_op: got %h cznv=%b lat=%0d want 0 0100 lat=1", r, f, lat);
        end
    endtask

    task automatic test_random();
        logic [3:0]  ops[8] = '{4'd0, 4'd1, 4'd2, 4'd4, 4'd12, 4'd10, 4'd11, 4'd9};
        logic [31:0] r, a, b;
        logic [3:0]  f, op;
        logic        ci;
        int lat, bc, k;
        exp_t e;
        for (int i = 0; i < 60; i++) begin
            k = int'($urandom_range(0, 8));
            op = (k == 8) ? 4'($urandom_range(0, 15)) : ops[k];
            a = $urandom;
            b = $urandom;
            ci = 1'($urandom);
            if (i % 7 == 0) a = {1'b0, a[30:0]} ^ 32'h8000_0000;
            if ((op == 4'd10 || op == 4'd11) && $urandom_range(0, 3) == 0) b[4:0] = 5'd0;
            e = model(op, a, b, ci);
            do_op(op, a, b, ci, r, f, lat, bc);
            n_tests++;
            if ({r, f} !== {e.res, e.c, e.z, e.n, e.v} || lat != e.lat) begin
                n_fail++;
                $display("FAIL random op=%b a=%h b=%h ci=%b: got %h cznv=%b lat=%0d want %h %b%b%b%b lat=%0d",
                         op, a, b, ci, r, f, lat, e.res, e.c, e.z, e.n, e.v, e.lat);
            end
        end
    endtask

    task automatic test_mul();
        logic [31:0] r;
        logic [3:0]  f;
        int lat, bc;
        if (MulEn) begin
            @(negedge clk);
            opCode = 4'b1001; datoA = 32'h1234; datoB = 32'h100; start = 1'b1;
            @(negedge clk);
            start = 1'b0;
            lat = 1;
            bc = 0;
            while (done !== 1'b1 && lat < 200) begin
                if (busy === 1'b1) bc++;
                datoA = $urandom;
                datoB = $urandom;
                start = (lat == 5);
                opCode = (lat == 5) ? 4'b0100 : 4'b1001;
                @(negedge clk);
                lat++;
            end
            start = 1'b0;
            n_tests++;
            if ({salida, cout, zero, neg, ovf} !== {32'h0012_3400, 4'b0000} || lat != W + 1
                || bc != W) begin
                n_fail++;
                $display("FAIL mul_directed: got %h cznv=%b%b%b%b lat=%0d busy=%0d want 00123400 0000 lat=%0d busy=%0d",
                         salida, cout, zero, neg, ovf, lat, bc, W + 1, W);
            end
            @(negedge clk);
            n_tests++;
            if ({done, busy} !== 2'b00) begin
                n_fail++;
                $display("FAIL mul_after: got done/busy=%b%b want 00", done, busy);
            end
        end else begin
            do_op(4'b1001, 32'h1234, 32'h100, 1'b0, r, f, lat, bc);
            n_tests++;
            if ({r, f, lat, bc} !== {32'h0, 4'b0100, 32'd1, 32'd0}) begin
                n_fail++;
                $display("FAIL mul_disabled: got %h cznv=%b lat=%0d busy=%0d want 0 0100 1 0",
                         r, f, lat, bc);
            end
        end
    endtask

    task automatic test_mul_reset();
        logic [31:0] r;
        logic [3:0]  f;
        int lat, bc, seen;
        do_op(4'b0100, 32'd7, 32'd8, 1'b0, r, f, lat, bc);
        if (MulEn) begin
            @(negedge clk);
            opCode = 4'b1001; datoA = $urandom; datoB = $urandom | 32'h1; start = 1'b1;
            @(negedge clk);
            start = 1'b0;
            repeat (9) @(negedge clk);
        end
        #2 rst_n = 1'b0;
        #1;
        n_tests++;
        if ({salida, cout, zero, neg, ovf, busy, done} !== {32'd0, 6'b010000}) begin
            n_fail++;
            $display("FAIL reset_mid_op: got salida=%h c/z/n/v/busy/done=%b%b%b%b%b%b want 0 010000",
                     salida, cout, zero, neg, ovf, busy, done);
        end
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done === 1'b1) seen++;
        end
        n_tests++;
        if (seen != 0) begin
            n_fail++;
            $display("FAIL reset_no_done: got %0d done pulses want 0", seen);
        end
        do_op(4'b0100, 32'd2, 32'd3, 1'b0, r, f, lat, bc);
        n_tests++;
        if ({r, lat} !== {32'd5, 32'd1}) begin
            n_fail++;
            $display("FAIL reset_then_add: got %h lat=%0d want 00000005 lat=1", r, lat);
        end
    endtask

    task automatic test_back_to_back();
        int n;
        @(negedge clk);
        opCode = 4'b0100; datoA = 32'd1; datoB = 32'd1; cin = 1'b0; start = 1'b1;
        @(negedge clk);
        n_tests++;
        if ({done, salida} !== {1'b1, 32'd2}) begin
            n_fail++;
            $display("FAIL b2b_first: got done=%b salida=%h want 1 00000002", done, salida);
        end
        opCode = 4'b0000; datoA = 32'hF0; datoB = 32'h3C;
        @(negedge clk);
        start = 1'b0;
        n_tests++;
        if ({done, salida} !== {1'b1, 32'h30}) begin
            n_fail++;
            $display("FAIL b2b_second: got done=%b salida=%h want 1 00000030", done, salida);
        end
        @(negedge clk);
        n_tests++;
        if ({done, salida} !== {1'b0, 32'h30}) begin
            n_fail++;
            $display("FAIL b2b_end: got done=%b salida=%h want 0 00000030", done, salida);
        end
        if (MulEn) begin
            @(negedge clk);
            opCode = 4'b1001; datoA = 32'd3; datoB = 32'd5; start = 1'b1;
            @(negedge clk);
            opCode = 4'b0100; datoA = 32'd10; datoB = 32'd20;
            n = 1;
            while (done !== 1'b1 && n < 200) begin
                @(negedge clk);
                n++;
            end
            n_tests++;
            if ({salida, n} !== {32'd15, W + 1}) begin
                n_fail++;
                $display("FAIL b2b_mul: got %h lat=%0d want 0000000f lat=%0d", salida, n, W + 1);
            end
            @(negedge clk);
            start = 1'b0;
            n_tests++;
            if ({done, salida} !== {1'b1, 32'd30}) begin
                n_fail++;
                $display("FAIL b2b_mul_add: got done=%b salida=%h want 1 0000001e", done, salida);
            end
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_mul();
        test_mul_reset();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
